// File: rtl/digi_ota_array.sv
// Multi-channel synchronous digital OTA: each channel syncs a vip/vin pair, integrates the
// difference in a saturating signed counter and drives a hysteretic comparator from it.
module digi_ota_array #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 6,
    parameter int HYST  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            clr,
    input  logic [1:0]      gain,
    input  logic [N_CH-1:0] vip,
    input  logic [N_CH-1:0] vin,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] active,
    output logic [N_CH-1:0] sat
);

    localparam logic signed [CNT_W:0]   MAX_X   = (CNT_W+1)'(2**(CNT_W-1) - 1);
    localparam logic signed [CNT_W:0]   MIN_X   = -((CNT_W+1)'(2**(CNT_W-1)));
    localparam logic signed [CNT_W-1:0] CNT_MAX = MAX_X[CNT_W-1:0];
    localparam logic signed [CNT_W-1:0] CNT_MIN = MIN_X[CNT_W-1:0];
    localparam logic signed [CNT_W-1:0] HYST_P  = (CNT_W)'(HYST);
    localparam logic signed [CNT_W-1:0] HYST_N  = -HYST_P;

    logic [N_CH-1:0]         vp_meta;
    logic [N_CH-1:0]         vp_sync;
    logic [N_CH-1:0]         vn_meta;
    logic [N_CH-1:0]         vn_sync;
    logic signed [CNT_W:0]   step;

    // The step is one shared magnitude, so every channel integrates with the same gain on an edge.
    assign step = (CNT_W+1)'(4'd1 << gain);

    // Synchronisers keep sampling through ena/clr so re-enabling adds no latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp_meta <= '0;
            vp_sync <= '0;
            vn_meta <= '0;
            vn_sync <= '0;
        end else begin
            vp_meta <= vip;
            vp_sync <= vp_meta;
            vn_meta <= vin;
            vn_sync <= vn_meta;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic signed [CNT_W-1:0] cnt;
        logic signed [CNT_W-1:0] cnt_next;
        logic signed [CNT_W:0]   cnt_ext;
        logic signed [CNT_W:0]   sum;
        logic                    up;
        logic                    dn;
        logic                    out_q;
        logic                    active_q;

        assign up      = vp_sync[i] & ~vn_sync[i];
        assign dn      = ~vp_sync[i] & vn_sync[i];
        assign cnt_ext = {cnt[CNT_W-1], cnt};

        // One extra bit of headroom lets the clamp catch overflow before it can wrap.
        always_comb begin
            sum = cnt_ext;
            if (up) begin
                sum = cnt_ext + step;
            end else if (dn) begin
                sum = cnt_ext - step;
            end
            if (sum > MAX_X) begin
                cnt_next = CNT_MAX;
            end else if (sum < MIN_X) begin
                cnt_next = CNT_MIN;
            end else begin
                cnt_next = sum[CNT_W-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                out_q    <= 1'b0;
                active_q <= 1'b0;
            end else if (clr) begin
                cnt      <= '0;
                out_q    <= 1'b0;
                active_q <= 1'b0;
            end else if (ena) begin
                cnt      <= cnt_next;
                active_q <= up | dn;
                if (cnt >= HYST_P) begin
                    out_q <= 1'b1;
                end else if (cnt <= HYST_N) begin
                    out_q <= 1'b0;
                end
            end
        end

        assign out[i]    = out_q;
        assign active[i] = active_q;
        assign sat[i]    = (cnt == CNT_MAX) || (cnt == CNT_MIN);
    end

endmodule
